config_bitstream_loader: RTL
============================

# config_bitstream_loader

Upstream configuration stage for `memory_tile_unq1` and the PE tiles. It accepts a stream of 32-bit bitstream address/data pairs, each with a write or read opcode, through a valid/ready handshake and buffers them in a small FIFO. It filters the pairs by tile ID and drives the tile's `config_addr`/`config_data` bus with a one-cycle write strobe. Read opcodes issue a read strobe, capture the tile's `read_data` and return it through a response handshake.

## Interface
- `FIFO_DEPTH`, 4: input FIFO entries; power of two, ≥2.
- `TILE_ID`, 16'h18: ID matched against `addr[15:0]`.
- `clk_in`  in  1  the single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  input pair valid.
- `in_ready`  out  1  FIFO can accept.
- `in_addr`  in  32  bitstream address: [15:0] tile ID, [23:16] feature, [31:24] register.
- `in_data`  in  32  bitstream data.
- `in_op`  in  1  0 = write, 1 = read.
- `in_last`  in  1  marks the final pair of the bitstream.
- `config_addr`  out  32  address to the tile.
- `config_data`  out  32  data to the tile.
- `config_en`  out  1  write strobe, one cycle per write.
- `config_read`  out  1  read strobe, one cycle per read.
- `read_data`  in  32  tile readback, valid 1 cycle after `config_read`.
- `rd_valid`  out  1  readback response valid.
- `rd_ready`  in  1  consumer accepts the response.
- `rd_data`  out  32  captured readback.
- `cfg_count`  out  16  writes issued to this tile; saturates at 16'hFFFF.
- `config_done`  out  1  sticky; set once the `in_last` pair has retired.

## Operation
- **FIFO**
  - A push occurs on `in_valid && in_ready`.
  - `in_ready = !full`.
  - Each entry stores {op, last, addr, data}, 66 bits.
- **FSM states:** IDLE, READ_REQ, READ_WAIT, RESP.
- **IDLE, FIFO non-empty:** the head is popped every cycle.
  - **Tile mismatch** (`addr[15:0] != TILE_ID`): the pair is dropped and no strobe is issued.
  - **Matching write:** `config_addr`/`config_data` are loaded, `config_en` = 1 next cycle, `cfg_count` increments. The FSM stays in IDLE, so back-to-back writes issue one per cycle.
  - **Matching read:** `config_addr` is loaded, `config_read` = 1 next cycle, and the FSM moves to READ_REQ.
- **READ_REQ → READ_WAIT:** unconditional. No pop occurs.
- **READ_WAIT:** `rd_data <= read_data`, `rd_valid <= 1`, then → RESP.
- **RESP:**
  - Holds `rd_valid`/`rd_data` stable until `rd_ready`.
  - On `rd_ready`: `rd_valid` clears and the FSM → IDLE. The next pop happens in the following cycle.
- **`config_done`:** set the cycle the strobe for the `in_last` pair asserts. For a dropped `in_last` pair it sets the cycle after the pop. For a read it sets on `rd_ready`. Further input after done is still processed; done stays 1.
- **`config_addr`/`config_data`:** hold their last value between strobes. They are not zeroed.

## Timing
- **Reset values:**
  - All outputs are 0 except `in_ready` = 1.
  - The FIFO is emptied and the FSM → IDLE.
- **Reset mid-operation:** an in-flight read is abandoned and no response is produced. Buffered pairs are discarded.
- **Write latency:** push at edge N → head visible, popped at edge N+1 → `config_en` high during cycle N+1..N+2. That is 2 cycles from acceptance into an empty FIFO.
- **Read turnaround:** after `config_read`, 2 cycles to `rd_valid`. The response is held for as long as `rd_ready` stays low.
- **Full FIFO:** a simultaneous pop and push in the same cycle is allowed, and `in_ready` reflects full before the pop. A push when full is ignored (`in_ready` = 0).
- **Pointers:** FIFO pointers wrap modulo `FIFO_DEPTH`, with an extra bit for full/empty.
- **Strobes:** `config_en` and `config_read` are never high together, and each is never high for 2 consecutive cycles per pair.
- **`cfg_count`:** 16-bit unsigned. Holds at FFFF and does not wrap.

## Structure
- **Package `cgra_cfg_pkg`:**
  - Field localparams: `TILE_ID_LSB/MSB` = 0/15, `FEATURE_LSB` = 16, `REG_LSB` = 24.
  - `cfg_op_t` enum: `CFG_WRITE` = 0, `CFG_READ` = 1.
  - FSM state enum.
- **Sub-module `cfg_fifo`:** parameterised width/depth synchronous FIFO with push/pop/full/empty. It is instantiated once. The FSM, filter, counter and done logic live in the top module.

## Test plan
- **Basic writes:** reset, then push 3 writes to tile 16'h18 (addrs 0x00010018, 0x00020018, 0x00030018; data 1, 2, 3) → `config_en` pulses on 3 consecutive cycles with matching addr/data, `cfg_count` = 3.
- **Filtering:** push a write with addr 0x00010019, then one with 0x00050018 → a single `config_en`, carrying 0x00050018. `cfg_count` = 1.
- **Readback:** push a read at 0x00FF0018 with the tile model returning 0xDEADBEEF and `rd_ready` held low for 5 cycles → `rd_valid` is stable with `rd_data` = 0xDEADBEEF until `rd_ready`. No `config_en` occurs meanwhile.
- **Backpressure:** stall the FSM in RESP and push 5 pairs with `FIFO_DEPTH` = 4 → `in_ready` drops after 4 accepts. After the response drains, all 4 buffered pairs issue in order.
- **Done:** push 2 writes, the second with `in_last` = 1 → `config_done` rises in the same cycle as the second `config_en` and stays 1.
- **Reset mid-read:** assert `reset` during READ_WAIT → the next cycle shows all outputs 0, `in_ready` = 1, and no `rd_valid` ever appears for that read.

Source files
------------

// File: rtl/cgra_cfg_pkg.sv
// Shared definitions for the configuration bitstream loader.
//   - Bit positions of the fields inside a 32-bit bitstream address.
//   - cfg_op_t: the opcode carried with each address/data pair.
//   - cfg_state_t: the loader FSM states.
//   - cfg_entry_t: one buffered pair {op, last, addr, data}, 66 bits.
package cgra_cfg_pkg;

    localparam int TILE_ID_LSB = 0;
    localparam int TILE_ID_MSB = 15;
    localparam int FEATURE_LSB = 16;
    localparam int REG_LSB     = 24;

    typedef enum logic {
        CFG_WRITE = 1'b0,
        CFG_READ  = 1'b1
    } cfg_op_t;

    typedef enum logic [1:0] {
        IDLE,
        READ_REQ,
        READ_WAIT,
        RESP
    } cfg_state_t;

    typedef struct packed {
        cfg_op_t     op;
        logic        last;
        logic [31:0] addr;
        logic [31:0] data;
    } cfg_entry_t;

    localparam int CFG_ENTRY_W = $bits(cfg_entry_t);

    function automatic logic [15:0] tile_id_of(input logic [31:0] addr);
        return addr[TILE_ID_MSB:TILE_ID_LSB];
    endfunction

    function automatic logic [7:0] feature_of(input logic [31:0] addr);
        return addr[FEATURE_LSB +: 8];
    endfunction

    function automatic logic [7:0] reg_of(input logic [31:0] addr);
        return addr[REG_LSB +: 8];
    endfunction

endpackage

// File: rtl/cfg_fifo.sv
// Synchronous FIFO with first-word fall-through read port.
// Ports:
//   clk_in, reset        : clock, synchronous active-high reset (empties FIFO)
//   push, wdata          : write request and data (ignored when full)
//   pop                  : advance the head (ignored when empty)
//   rdata                : current head entry
//   full, empty          : occupancy flags
module cfg_fifo #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 4
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk_in) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) begin
                wptr <= wptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge clk_in) begin
        if (push && !full) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/config_bitstream_loader.sv
// Configuration bitstream loader: buffers address/data pairs in a FIFO,
// filters them by tile ID and drives the tile configuration bus.
// Ports:
//   clk_in, reset               : clock, synchronous active-high reset
//   in_valid/in_ready           : input pair handshake
//   in_addr, in_data, in_op,
//   in_last                     : pair contents (op 0 = write, 1 = read)
//   config_addr, config_data    : tile bus, held between strobes
//   config_en, config_read      : one-cycle write / read strobes
//   read_data                   : tile readback, valid 1 cycle after config_read
//   rd_valid/rd_ready, rd_data  : readback response handshake
//   cfg_count                   : saturating count of writes to this tile
//   config_done                 : sticky, set once the last pair retires
module config_bitstream_loader
    import cgra_cfg_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] TILE_ID    = 16'h18
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    input  logic        in_op,
    input  logic        in_last,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        config_en,
    output logic        config_read,
    input  logic [31:0] read_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic [15:0] cfg_count,
    output logic        config_done
);

    cfg_entry_t push_entry;
    cfg_entry_t head;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic       hit;
    logic       read_last;

    cfg_state_t state;
    cfg_state_t next_state;

    assign in_ready   = !full;
    assign push       = in_valid && !full;
    assign push_entry = '{op: cfg_op_t'(in_op), last: in_last, addr: in_addr, data: in_data};
    assign hit        = (tile_id_of(head.addr) == TILE_ID);

    cfg_fifo #(
        .WIDTH (CFG_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in (clk_in),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .wdata  (push_entry),
        .rdata  (head),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The head is consumed only in IDLE; a matching read parks the FSM
    // until its response has been accepted.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (hit && head.op == CFG_READ) begin
                        next_state = READ_REQ;
                    end
                end
            end
            READ_REQ:  next_state = READ_WAIT;
            READ_WAIT: next_state = RESP;
            RESP: begin
                if (rd_ready) begin
                    next_state = IDLE;
                end
            end
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            config_addr <= '0;
            config_data <= '0;
            config_en   <= 1'b0;
            config_read <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            cfg_count   <= '0;
            config_done <= 1'b0;
            read_last   <= 1'b0;
        end else begin
            config_en   <= 1'b0;
            config_read <= 1'b0;
            if (pop) begin
                if (hit) begin
                    config_addr <= head.addr;
                    if (head.op == CFG_WRITE) begin
                        config_data <= head.data;
                        config_en   <= 1'b1;
                        if (cfg_count != 16'hFFFF) begin
                            cfg_count <= cfg_count + 16'd1;
                        end
                        if (head.last) begin
                            config_done <= 1'b1;
                        end
                    end else begin
                        config_read <= 1'b1;
                        read_last   <= head.last;
                    end
                end else if (head.last) begin
                    // A dropped final pair still completes the bitstream.
                    config_done <= 1'b1;
                end
            end
            if (state == READ_WAIT) begin
                rd_data  <= read_data;
                rd_valid <= 1'b1;
            end
            if (state == RESP && rd_ready) begin
                rd_valid <= 1'b0;
                if (read_last) begin
                    config_done <= 1'b1;
                end
            end
        end
    end

endmodule
